fetch_buffer: RTL

Instruction prefetch buffer between instruction memory and `decode_stage`: it owns the fetch PC and issues one sequential instruction-memory read per cycle when it has credit. Returned instructions are queued with their PC and presented to decode through a valid/ready handshake. A branch redirect flushes the queue and kills any in-flight read. This decouples decode stalls from fetch, so the pipeline can hold decode without losing fetched instructions.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/fetch_buffer.sv | 102 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU widths, reset address, fetch queue entry type and
//               the opcode constants used by decode.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int             PC_W             = 16;
    localparam int             INSTR_W          = 32;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    // Major opcodes (RV32I encoding) consumed by decode_stage
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Instruction format classes
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_fmt_t;

    // One queued fetch result: instruction word plus the address it came from
    typedef struct packed {
        logic [INSTR_W-1:0] ir;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    // Sequential fetch address; wraps modulo 2^16
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry synchronous FIFO of fetch entries with push, pop,
//               flush, occupancy count and combinational head output.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         push_i,
    input  fetch_entry_t                 push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output fetch_entry_t                 head_o
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next pointers/count; flush wins over any push or pop in the same cycle
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until counted valid, so no reset
    always_ff @(posedge CLK) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Instruction prefetch buffer. Owns the fetch PC, issues one
//               sequential read per cycle while credit allows, queues returned
//               words with their PC and hands them to decode via valid/ready.
//               A redirect flushes the queue and kills the in-flight read.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                REDIRECT,
    input  logic [PC_W-1:0]     REDIRECT_PC,
    output logic                IM_REQ,
    output logic [PC_W-1:0]     IM_ADDR,
    input  logic [INSTR_W-1:0]  IM_DATA,
    output logic                DE_V,
    output logic [INSTR_W-1:0]  DE_IR,
    output logic [PC_W-1:0]     DE_PC,
    input  logic                DE_READY
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_occ;
    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_data;

    // A pop frees a slot in the same cycle, which is why DE_READY reaches
    // IM_REQ combinationally. RST_N gates issue so the request drops as soon
    // as reset asserts, without waiting for a clock edge.
    assign DE_V    = (w_count != '0) & ~REDIRECT;
    assign w_pop   = DE_V & DE_READY;
    assign w_occ   = {1'b0, w_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(w_pop);
    assign w_issue = RST_N & ~REDIRECT & (w_occ < (CNT_W+1)'(DEPTH));
    assign w_push  = inflight_q & ~REDIRECT;

    assign IM_REQ  = w_issue;
    assign IM_ADDR = pc_q;

    assign w_push_data.ir = IM_DATA;
    assign w_push_data.pc = inflight_pc_q;

    assign DE_IR = w_head.ir;
    assign DE_PC = w_head.pc;

    // Next fetch PC and in-flight tracking; redirect overrides issue
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (REDIRECT) begin
            pc_d = {REDIRECT_PC[PC_W-1:2], 2'b00};
        end else if (w_issue) begin
            pc_d          = pc_next(pc_q);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    // Fetch PC and in-flight state registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .flush_i     (REDIRECT),
        .count_o     (w_count),
        .head_o      (w_head)
    );

endmodule
`default_nettype wire
